// File: rtl/uart_rx_fsm_if.sv
// Serial receive bundle: line in, byte/status out.
// master = receiver side, slave = line driver / consumer side.
interface uart_rx_fsm_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start, 8 data LSB-first, parity, 1 stop.
// Oversampled line, centre sampling, 1-cycle result strobe.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fsm_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx;
  logic [2:0]    idx_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          pbit;
  logic          pbit_d;
  logic          done;

  logic          rx_m;
  logic          rx_s;
  logic          rx_q;

  logic [7:0]    data_r;
  logic          valid_r;
  logic          perr_r;
  logic          ferr_r;

  // rx_q trails rx_s so a falling edge is rx_q & ~rx_s
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      pbit  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      pbit  <= pbit_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    shift_d = shift;
    pbit_d  = pbit;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (rx_q && !rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt == MID) begin
          cnt_d = '0;
          idx_d = '0;
          // a line back high at mid-start is a glitch
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          pbit_d  = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      valid_r <= done;
      if (done) begin
        data_r <= shift;
        perr_r <= ^shift ^ pbit ^ PARITY_ODD;
        ferr_r <= ~rx_s;
      end
    end
  end

  assign bus.rx_data    = data_r;
  assign bus.rx_valid   = valid_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err  = ferr_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clk/bit, even parity.
// Strobes, latency and busy activity are tracked by a negedge monitor.
module tb_uart_rx_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(
    .CLKS_PER_BIT (16),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int strobes  = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  int dbl      = 0;
  int busy_cnt = 0;
  logic vprev  = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      strobes  <= strobes + 1;
      last_cyc <= cyc;
      prev_cyc <= last_cyc;
      if (vprev) dbl <= dbl + 1;
    end
    vprev <= bus.rx_valid;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(logic b, int n);
    bus.rx = b;
    tick(n);
  endtask

  task automatic send(logic [7:0] d, logic p, logic s, int stop_len);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    drive_bit(p, 16);
    drive_bit(s, stop_len);
  endtask

  int s0;
  int b0;
  int fall;

  initial begin
    bus.rx = 1'b1;
    tick(3);
    chk("rst_data", {24'h0, bus.rx_data}, 32'h00);
    chk("rst_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("rst_perr", {31'h0, bus.parity_err}, 32'h0);
    chk("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b1;
    tick(10);

    // 1: good frame, latency from pin fall
    s0   = strobes;
    fall = cyc;
    send(8'hA5, 1'b0, 1'b1, 16);
    tick(10);
    chk("t1_strobes", strobes - s0, 1);
    chk("t1_latency", last_cyc - fall, 171);
    chk("t1_data", {24'h0, bus.rx_data}, 32'hA5);
    chk("t1_perr", {31'h0, bus.parity_err}, 32'h0);
    chk("t1_ferr", {31'h0, bus.frame_err}, 32'h0);

    // 2: wrong parity
    s0 = strobes;
    send(8'h01, 1'b0, 1'b1, 16);
    tick(10);
    chk("t2_strobes", strobes - s0, 1);
    chk("t2_data", {24'h0, bus.rx_data}, 32'h01);
    chk("t2_perr", {31'h0, bus.parity_err}, 32'h1);
    chk("t2_ferr", {31'h0, bus.frame_err}, 32'h0);

    // 3: stop low, line held low 40 clk then high
    s0 = strobes;
    send(8'h3C, 1'b0, 1'b0, 40);
    drive_bit(1'b1, 40);
    chk("t3_strobes", strobes - s0, 1);
    chk("t3_data", {24'h0, bus.rx_data}, 32'h3C);
    chk("t3_perr", {31'h0, bus.parity_err}, 32'h0);
    chk("t3_ferr", {31'h0, bus.frame_err}, 32'h1);
    chk("t3_busy", {31'h0, bus.busy}, 32'h0);

    // 4: 3-clk glitch
    s0 = strobes;
    b0 = busy_cnt;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    chk("t4_busy_seen", {31'h0, (busy_cnt > b0)}, 32'h1);
    chk("t4_strobes", strobes - s0, 0);
    chk("t4_busy", {31'h0, bus.busy}, 32'h0);
    chk("t4_data", {24'h0, bus.rx_data}, 32'h3C);
    chk("t4_ferr", {31'h0, bus.frame_err}, 32'h1);

    // 5: reset during data bit 4, then a clean frame
    s0 = strobes;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    chk("t5_busy_pre", {31'h0, bus.busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_data", {24'h0, bus.rx_data}, 32'h00);
    chk("t5_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("t5_perr", {31'h0, bus.parity_err}, 32'h0);
    chk("t5_ferr", {31'h0, bus.frame_err}, 32'h0);
    chk("t5_busy", {31'h0, bus.busy}, 32'h0);
    bus.rx = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(20);
    chk("t5_no_strobe", strobes - s0, 0);
    send(8'h5A, 1'b0, 1'b1, 16);
    tick(10);
    chk("t5_strobes", strobes - s0, 1);
    chk("t5_data2", {24'h0, bus.rx_data}, 32'h5A);
    chk("t5_perr2", {31'h0, bus.parity_err}, 32'h0);
    chk("t5_ferr2", {31'h0, bus.frame_err}, 32'h0);

    // 6: back-to-back frames, no idle gap
    s0 = strobes;
    send(8'h00, 1'b0, 1'b1, 16);
    chk("t6_data0", {24'h0, bus.rx_data}, 32'h00);
    chk("t6_perr0", {31'h0, bus.parity_err}, 32'h0);
    send(8'hFF, 1'b0, 1'b1, 16);
    tick(10);
    chk("t6_strobes", strobes - s0, 2);
    chk("t6_gap", last_cyc - prev_cyc, 176);
    chk("t6_data1", {24'h0, bus.rx_data}, 32'hFF);
    chk("t6_perr1", {31'h0, bus.parity_err}, 32'h0);
    chk("t6_ferr1", {31'h0, bus.frame_err}, 32'h0);

    chk("valid_single", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
